fft_window: RTL and testbench



---
 rtl/fft_window_pkg.sv | 19 +
 rtl/fft_window_if.sv | 22 ++
 rtl/fft_window_mac.sv | 48 ++++
 rtl/fft_window.sv | 177 +++++++++++++++++
 tb/tb_fft_window.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_window_pkg.sv
// fft_pkg: shared constants for the FFT windowing stage.
//   DATA_W_DEF / COEF_W_DEF : default component and coefficient widths
//   COEF_ONE                : Q1.15 value closest to +1.0, the power-up coefficient
//   RE_LSB / IM_LSB         : component offsets inside a 2*DATA_W tdata word
//   SAT_MAX / SAT_MIN       : saturation limits for a default-width component
package fft_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int COEF_W_DEF = 16;

    localparam logic signed [COEF_W_DEF-1:0] COEF_ONE = 16'sh7FFF;

    localparam int RE_LSB = 0;
    localparam int IM_LSB = DATA_W_DEF;

    localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/fft_window_if.sv
// fft_window_if: AXI4-Stream style bundle carrying complex samples.
//   tvalid / tready : handshake
//   tlast           : last sample of a frame
//   tdata           : {im, re}, each DATA_W bits signed
// Modports:
//   master : drives tvalid/tlast/tdata, receives tready
//   slave  : receives tvalid/tlast/tdata, drives tready
interface fft_window_if
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic [2*DATA_W-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);

endinterface

// File: rtl/fft_window_mac.sv
// fft_window_mac: combinational multiply / round / saturate of one signed
// component by one signed Q1.(COEF_W-1) coefficient.
//   x_i : signed sample component, DATA_W bits
//   c_i : signed coefficient, COEF_W bits
//   y_o : round-half-up, saturated product, DATA_W bits
// The result register lives in the parent.
module fft_window_mac #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 16
) (
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [COEF_W-1:0] c_i,
    output logic signed [DATA_W-1:0] y_o
);

    // One guard bit above the full product keeps the rounding add from
    // wrapping for the (-1.0 * most-negative) corner.
    localparam int PW = DATA_W + COEF_W + 1;

    localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] half;
        half = '0;
        half[COEF_W-2] = 1'b1;
        return (p + half) >>> (COEF_W - 1);
    endfunction

    // Fits when every bit from the sign position upward agrees.
    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [PW-1:0] v);
        logic [PW-DATA_W:0] top;
        top = v[PW-1:DATA_W-1];
        if ((top == '0) || (top == '1)) begin
            return v[DATA_W-1:0];
        end else if (v[PW-1]) begin
            return Y_MIN;
        end else begin
            return Y_MAX;
        end
    endfunction

    logic signed [PW-1:0] prod;

    assign prod = PW'(x_i) * PW'(c_i);
    assign y_o  = saturate(round_shift(prod));

endmodule

// File: rtl/fft_window.sv
// fft_window: windowing stage between the FFT sample buffer and the FFT core.
// Each complex beat is multiplied by a per-bin real coefficient taken from a
// writable NFFT-entry RAM indexed by the position of the beat in its frame.
// Two-stage elastic pipeline with full backpressure.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   cWAddr/cWData/cWEn: coefficient RAM write port (read-first vs. the stream)
//   errClr            : clears the sticky frameErr flag (a same-cycle set wins)
//   s_axis (slave)    : input samples {im, re}
//   m_axis (master)   : windowed samples, same packing, tlast delayed
//   frameErr          : sticky tlast / bin-index mismatch flag
//
// Build option: define FFT_WINDOW_BYPASS_EN to add the 'bypass' input; a beat
// flagged with it passes through bit-exactly with unchanged latency.
module fft_window
    import fft_pkg::*;
#(
    parameter int NFFT   = 8,
    parameter int DATA_W = DATA_W_DEF,
    parameter int COEF_W = COEF_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [$clog2(NFFT)-1:0] cWAddr,
    input  logic [COEF_W-1:0]       cWData,
    input  logic                    cWEn,
    input  logic                    errClr,
`ifdef FFT_WINDOW_BYPASS_EN
    input  logic                    bypass,
`endif
    fft_window_if.slave             s_axis,
    fft_window_if.master            m_axis,
    output logic                    frameErr
);

    localparam int AW     = $clog2(NFFT);
    localparam int IM_OFS = RE_LSB + DATA_W;
    localparam logic signed [COEF_W-1:0] COEF_INIT = {1'b0, {(COEF_W-1){1'b1}}};

    // Power-up contents only; reset deliberately leaves the table alone.
    logic signed [COEF_W-1:0] coef_mem [NFFT] = '{default: COEF_INIT};

    logic                     p2_load;
    logic                     p1_adv;
    logic                     s_rdy;
    logic                     accept;

    logic [AW-1:0]            idx_q, idx_d;
    logic                     idx_last;
    logic                     frame_err_q, frame_err_d;

    logic                     vld_p1_q;
    logic signed [DATA_W-1:0] re_p1_q;
    logic signed [DATA_W-1:0] im_p1_q;
    logic signed [COEF_W-1:0] coef_p1_q;
    logic                     last_p1_q;
`ifdef FFT_WINDOW_BYPASS_EN
    logic                     byp_p1_q;
`endif

    logic signed [DATA_W-1:0] y_re;
    logic signed [DATA_W-1:0] y_im;
    logic [2*DATA_W-1:0]      data_p2_d;

    logic                     vld_p2_q;
    logic [2*DATA_W-1:0]      data_p2_q;
    logic                     last_p2_q;

    // A stage loads when empty or when its current content leaves this cycle.
    assign p2_load  = !vld_p2_q || m_axis.tready;
    assign p1_adv   = vld_p1_q && p2_load;
    assign s_rdy    = !reset && (!vld_p1_q || p1_adv);
    assign accept   = s_axis.tvalid && s_rdy;
    assign idx_last = (idx_q == AW'(NFFT - 1));

    always_ff @(posedge clk) begin
        if (cWEn) begin
            coef_mem[cWAddr] <= $signed(cWData);
        end
    end

    // Bin index and sticky framing error. A mismatch is tlast disagreeing
    // with "this is bin NFFT-1"; the index restarts either way.
    always_comb begin
        idx_d       = idx_q;
        frame_err_d = frame_err_q;
        if (errClr) begin
            frame_err_d = 1'b0;
        end
        if (accept) begin
            if (s_axis.tlast || idx_last) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + AW'(1);
            end
            if (s_axis.tlast != idx_last) begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---- stage 1: capture sample, tlast and coefficient (synchronous read) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
        end else if (accept) begin
            vld_p1_q <= 1'b1;
        end else if (p1_adv) begin
            vld_p1_q <= 1'b0;
        end
    end

    // Reading coef_mem here while a write lands on the same edge returns the
    // old entry, which gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (accept) begin
            re_p1_q   <= $signed(s_axis.tdata[RE_LSB +: DATA_W]);
            im_p1_q   <= $signed(s_axis.tdata[IM_OFS +: DATA_W]);
            coef_p1_q <= coef_mem[idx_q];
            last_p1_q <= s_axis.tlast;
`ifdef FFT_WINDOW_BYPASS_EN
            byp_p1_q  <= bypass;
`endif
        end
    end

    fft_window_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac_re (
        .x_i (re_p1_q),
        .c_i (coef_p1_q),
        .y_o (y_re)
    );

    fft_window_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac_im (
        .x_i (im_p1_q),
        .c_i (coef_p1_q),
        .y_o (y_im)
    );

`ifdef FFT_WINDOW_BYPASS_EN
    assign data_p2_d = byp_p1_q ? {im_p1_q, re_p1_q} : {y_im, y_re};
`else
    assign data_p2_d = {y_im, y_re};
`endif

    // ---- stage 2: register the windowed result, held while stalled ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            data_p2_q <= '0;
        end else if (p2_load) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                last_p2_q <= last_p1_q;
                data_p2_q <= data_p2_d;
            end
        end
    end

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = vld_p2_q;
    assign m_axis.tlast  = last_p2_q;
    assign m_axis.tdata  = data_p2_q;
    assign frameErr      = frame_err_q;

endmodule

// File: tb/tb_fft_window.sv
// Self-checking bench for fft_window (NFFT=8, DATA_W=32, COEF_W=16).
// A reference model computes each expected output beat when the input beat is
// accepted and pushes it into a scoreboard queue; output beats pop and compare.
module tb_fft_window;
    import fft_pkg::*;

    localparam int NFFT = 8;
    localparam int DW   = 32;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    cWAddr;
    logic [CW-1:0] cWData;
    logic          cWEn;
    logic          errClr;
    logic          frameErr;

    fft_window_if #(.DATA_W(DW)) s_if ();
    fft_window_if #(.DATA_W(DW)) m_if ();

    fft_window #(.NFFT(NFFT), .DATA_W(DW), .COEF_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cWAddr   (cWAddr),
        .cWData   (cWData),
        .cWEn     (cWEn),
        .errClr   (errClr),
        .s_axis   (s_if),
        .m_axis   (m_if),
        .frameErr (frameErr)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;
    int cyc  = 0;

    logic [64:0]          sb[$];
    logic signed [CW-1:0] coef_m [NFFT];
    int                   idx_m;
    bit                   err_m;

    // Reference: p = x*c; y = (p + 2^14) >>> 15; clamp to 32-bit signed.
    function automatic logic [31:0] win(input logic [31:0] x, input logic [15:0] c);
        longint p, y;
        p = longint'($signed(x)) * longint'($signed(c));
        y = (p + 64'sd16384) >>> 15;
        if (y > 64'sd2147483647) y = 64'sd2147483647;
        else if (y < -64'sd2147483648) y = -64'sd2147483648;
        return y[31:0];
    endfunction

    task automatic drive(input logic [31:0] re, input logic [31:0] im, input bit last);
        s_if.tvalid = 1'b1;
        s_if.tlast  = last;
        s_if.tdata  = {im, re};
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
    endtask

    // One clock: observe handshakes just before the edge, update the model,
    // then return at the following falling edge.
    task automatic step(output bit ifire, output bit ofire,
                        output logic [64:0] obs, output logic [64:0] exp);
        #1;
        ifire = s_if.tvalid && s_if.tready;
        ofire = m_if.tvalid && m_if.tready;
        obs   = {m_if.tlast, m_if.tdata};
        exp   = 'x;
        if (ofire && sb.size() > 0) exp = sb.pop_front();
        if (errClr) err_m = 1'b0;
        if (ifire) begin
            sb.push_back({s_if.tlast, win(s_if.tdata[63:32], coef_m[idx_m]),
                          win(s_if.tdata[31:0], coef_m[idx_m])});
            if (s_if.tlast != (idx_m == NFFT - 1)) err_m = 1'b1;
            idx_m = (s_if.tlast || idx_m == NFFT - 1) ? 0 : idx_m + 1;
        end
        if (cWEn) coef_m[cWAddr] = cWData;
        if (reset) begin
            sb.delete();
            idx_m = 0;
            err_m = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
        bit fi, fo;
        logic [64:0] ob, ex;
        cWEn = 1'b1; cWAddr = a; cWData = d;
        idle();
        step(fi, fo, ob, ex);
        cWEn = 1'b0;
    endtask

    task automatic test_reset();
        bit fi, fo;
        logic [64:0] ob, ex;
        reset = 1'b1; idle(); m_if.tready = 1'b1;
        repeat (3) step(fi, fo, ob, ex);
        vecs++; if (s_if.tready !== 1'b0) begin miss++; $display("FAIL reset_s_tready: got %b, expected 0", s_if.tready); end
        vecs++; if (m_if.tvalid !== 1'b0) begin miss++; $display("FAIL reset_m_tvalid: got %b, expected 0", m_if.tvalid); end
        vecs++; if (m_if.tlast !== 1'b0) begin miss++; $display("FAIL reset_m_tlast: got %b, expected 0", m_if.tlast); end
        vecs++; if (m_if.tdata !== 64'h0) begin miss++; $display("FAIL reset_m_tdata: got %h, expected 0", m_if.tdata); end
        vecs++; if (frameErr !== 1'b0) begin miss++; $display("FAIL reset_frameErr: got %b, expected 0", frameErr); end
        reset = 1'b0;
        #1;
        vecs++; if (s_if.tready !== 1'b1) begin miss++; $display("FAIL post_reset_s_tready: got %b, expected 1", s_if.tready); end
    endtask

    task automatic test_default();
        bit fi, fo;
        logic [64:0] ob, ex;
        int k = 0, n = 0, t_in = -1, t_out = -1;
        m_if.tready = 1'b1;
        for (int c = 0; c < 40 && (k < 8 || sb.size() > 0); c++) begin
            if (k < 8) drive(32'd1000, -32'sd1000, k == 7); else idle();
            step(fi, fo, ob, ex);
            if (fi && t_in < 0) t_in = cyc;
            if (fo) begin
                if (t_out < 0) t_out = cyc;
                vecs++; if (ob !== ex) begin miss++; $display("FAIL default_beat %0d: got %h, expected %h", n, ob, ex); end
                vecs++; if (ob !== {n == 7, 32'hFFFFFC18, 32'd1000}) begin miss++; $display("FAIL default_value %0d: got %h, expected re=1000 im=-1000 last=%0d", n, ob, n == 7); end
                n++;
            end
            if (fi) k++;
        end
        idle();
        vecs++; if (n !== 8) begin miss++; $display("FAIL default_count: got %0d beats, expected 8", n); end
        vecs++; if (t_out - t_in !== 2) begin miss++; $display("FAIL default_latency: got %0d cycles, expected 2", t_out - t_in); end
    endtask

    task automatic test_coef_write();
        bit fi, fo;
        logic [64:0] ob, ex;
        int k = 0, n = 0;
        wr_coef(3'd3, 16'h4000);
        m_if.tready = 1'b1;
        for (int c = 0; c < 40 && (k < 8 || sb.size() > 0); c++) begin
            if (k < 8) drive(32'(100 * k), 32'd0, k == 7); else idle();
            step(fi, fo, ob, ex);
            if (fo) begin
                vecs++; if (ob !== ex) begin miss++; $display("FAIL coef_beat %0d: got %h, expected %h", n, ob, ex); end
                if (n == 3) begin vecs++; if (ob[31:0] !== 32'd150) begin miss++; $display("FAIL coef_beat3_re: got %0d, expected 150", ob[31:0]); end end
                if (n == 7) begin vecs++; if (ob[31:0] !== 32'd700) begin miss++; $display("FAIL coef_beat7_re: got %0d, expected 700", ob[31:0]); end end
                n++;
            end
            if (fi) k++;
        end
        idle();
        vecs++; if (k !== 8 || sb.size() !== 0) begin miss++; $display("FAIL coef_drain: got %0d sent %0d pending, expected 8 sent 0 pending", k, sb.size()); end
        vecs++; if (frameErr !== 1'b0) begin miss++; $display("FAIL coef_frameErr: got %b, expected 0", frameErr); end
    endtask

    task automatic test_saturate();
        bit fi, fo;
        logic [64:0] ob, ex;
        int k = 0, n = 0;
        wr_coef(3'd0, 16'h8000);
        m_if.tready = 1'b1;
        for (int c = 0; c < 40 && (k < 8 || sb.size() > 0); c++) begin
            if (k == 0) drive(32'h80000000, 32'h7FFFFFFF, 1'b0);
            else if (k < 8) drive(32'(7 * k), -32'(3 * k), k == 7);
            else idle();
            step(fi, fo, ob, ex);
            if (fo) begin
                vecs++; if (ob !== ex) begin miss++; $display("FAIL sat_beat %0d: got %h, expected %h", n, ob, ex); end
                if (n == 0) begin
                    vecs++; if (ob[31:0] !== 32'h7FFFFFFF) begin miss++; $display("FAIL sat_re: got %h, expected 7fffffff", ob[31:0]); end
                    vecs++; if (ob[63:32] !== 32'h80000001) begin miss++; $display("FAIL sat_im: got %h, expected 80000001", ob[63:32]); end
                end
                n++;
            end
            if (fi) k++;
        end
        idle();
        vecs++; if (k !== 8 || sb.size() !== 0) begin miss++; $display("FAIL sat_drain: got %0d sent %0d pending, expected 8 sent 0 pending", k, sb.size()); end
        wr_coef(3'd0, 16'h7FFF);
    endtask

    task automatic test_backpressure();
        bit fi, fo, stall;
        logic [64:0] ob, ex, held;
        logic [31:0] re_v, im_v;
        int k = 0, n = 0;
        stall = 1'b0; held = '0;
        re_v = $urandom; im_v = $urandom;
        for (int c = 0; c < 60 && (k < 8 || sb.size() > 0); c++) begin
            m_if.tready = (c % 2 == 1);
            if (k < 8) drive(re_v, im_v, k == 7); else idle();
            #1;
            vecs++; if (s_if.tready !== !(sb.size() == 2 && !m_if.tready)) begin miss++; $display("FAIL bp_s_tready cyc %0d: got %b, expected %b", c, s_if.tready, !(sb.size() == 2 && !m_if.tready)); end
            if (stall) begin vecs++; if ({m_if.tlast, m_if.tdata} !== held) begin miss++; $display("FAIL bp_stable cyc %0d: got %h, expected %h", c, {m_if.tlast, m_if.tdata}, held); end end
            stall = m_if.tvalid && !m_if.tready;
            held  = {m_if.tlast, m_if.tdata};
            step(fi, fo, ob, ex);
            if (fo) begin
                vecs++; if (ob !== ex) begin miss++; $display("FAIL bp_beat %0d: got %h, expected %h", n, ob, ex); end
                n++;
            end
            if (fi) begin k++; re_v = $urandom; im_v = $urandom; end
        end
        idle();
        m_if.tready = 1'b1;
        vecs++; if (n !== 8 || sb.size() !== 0) begin miss++; $display("FAIL bp_count: got %0d out %0d pending, expected 8 out 0 pending", n, sb.size()); end
    endtask

    task automatic test_frame_err();
        bit fi, fo;
        logic [64:0] ob, ex;
        int k = 0, n = 0;
        wr_coef(3'd0, 16'h2000);
        m_if.tready = 1'b1;
        for (int c = 0; c < 60 && (k < 13 || sb.size() > 0); c++) begin
            if (k < 13) drive(32'(4000 + 4 * k), -32'(8 * k), k == 4 || k == 12); else idle();
            step(fi, fo, ob, ex);
            if (fo) begin
                vecs++; if (ob !== ex) begin miss++; $display("FAIL ferr_beat %0d: got %h, expected %h", n, ob, ex); end
                if (n == 5) begin vecs++; if (ob[31:0] !== 32'd1005) begin miss++; $display("FAIL ferr_restart_coef0: got %0d, expected 1005", ob[31:0]); end end
                n++;
            end
            if (fi) k++;
        end
        idle();
        vecs++; if (frameErr !== 1'b1) begin miss++; $display("FAIL ferr_set: got %b, expected 1", frameErr); end
        errClr = 1'b1;
        step(fi, fo, ob, ex);
        errClr = 1'b0;
        vecs++; if (frameErr !== 1'b0) begin miss++; $display("FAIL ferr_clear: got %b, expected 0", frameErr); end
    endtask

    task automatic test_reset_midframe();
        bit fi, fo;
        logic [64:0] ob, ex;
        int k = 0, n = 0;
        wr_coef(3'd0, 16'h6000);
        m_if.tready = 1'b1;
        for (int c = 0; c < 10 && k < 3; c++) begin
            drive(32'(500 + k), 32'(k), 1'b0);
            step(fi, fo, ob, ex);
            if (fo) begin vecs++; if (ob !== ex) begin miss++; $display("FAIL rst_pre_beat: got %h, expected %h", ob, ex); end end
            if (fi) k++;
        end
        reset = 1'b1;
        drive(32'd12345, 32'd0, 1'b0);
        step(fi, fo, ob, ex);
        if (fo) begin vecs++; if (ob !== ex) begin miss++; $display("FAIL rst_inflight_beat: got %h, expected %h", ob, ex); end end
        reset = 1'b0;
        idle();
        vecs++; if (m_if.tvalid !== 1'b0) begin miss++; $display("FAIL rst_tvalid: got %b, expected 0", m_if.tvalid); end
        k = 0;
        for (int c = 0; c < 40 && (k < 8 || sb.size() > 0); c++) begin
            if (k < 8) drive(32'(1000 * (k + 1)), 32'(k), k == 7); else idle();
            step(fi, fo, ob, ex);
            if (fo) begin
                vecs++; if (ob !== ex) begin miss++; $display("FAIL rst_beat %0d: got %h, expected %h", n, ob, ex); end
                if (n == 0) begin vecs++; if (ob[31:0] !== 32'd750) begin miss++; $display("FAIL rst_first_coef0: got %0d, expected 750", ob[31:0]); end end
                if (n == 3) begin vecs++; if (ob[31:0] !== 32'd2000) begin miss++; $display("FAIL rst_coef3_kept: got %0d, expected 2000", ob[31:0]); end end
                n++;
            end
            if (fi) k++;
        end
        idle();
        vecs++; if (n !== 8 || sb.size() !== 0) begin miss++; $display("FAIL rst_count: got %0d out %0d pending, expected 8 out 0 pending", n, sb.size()); end
        vecs++; if (frameErr !== 1'b0) begin miss++; $display("FAIL rst_frameErr: got %b, expected 0", frameErr); end
    endtask

    initial begin
        reset = 1'b1; cWEn = 1'b0; cWAddr = '0; cWData = '0; errClr = 1'b0;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0;
        m_if.tready = 1'b1;
        for (int i = 0; i < NFFT; i++) coef_m[i] = 16'sh7FFF;
        idx_m = 0; err_m = 1'b0;
        @(negedge clk);
        test_reset();
        test_default();
        test_coef_write();
        test_saturate();
        test_backpressure();
        test_frame_err();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, expected bench to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
